usb_reg_fe_sync: RTL and testbench
==================================

Name: usb_reg_fe_sync

Overview:
Upstream front-end for the register block. It converts the asynchronous CW305 host parallel bus (address, data, chip enable, read/write strobes) into the usb_clk-domain register interface: reg_address, reg_bytecnt, write_data, reg_read, reg_write and read_data. Strobes are synchronized and edge-detected, with exactly one register access per host strobe. Read data is captured after a fixed latency and driven back to the host while the read strobe is held.

Parameters:
pBYTECNT_SIZE, 7, width of reg_bytecnt; low address bits.
pADDR_WIDTH, 21, host address width; must be >= pBYTECNT_SIZE+8.
pREAD_LATENCY, 1, usb_clk cycles from reg_read high to read_data valid.
pSYNC_STAGES, 2, flip-flop stages on usb_cen/usb_rdn/usb_wrn (>=2).

Ports:
usb_clk  in  1  sole clock
fpga_reset  in  1  synchronous, active-high reset
usb_addr  in  pADDR_WIDTH  host address (async, stable for the strobe duration)
usb_din  in  8  host write data (async, stable for the strobe duration)
usb_dout  out  8  read data to host
usb_isout  out  1  host data-bus output enable
usb_cen  in  1  chip enable, active low
usb_rdn  in  1  read strobe, active low
usb_wrn  in  1  write strobe, active low
reg_address  out  8  = usb_addr[pBYTECNT_SIZE+7:pBYTECNT_SIZE], latched
reg_bytecnt  out  pBYTECNT_SIZE  = usb_addr[pBYTECNT_SIZE-1:0], latched
write_data  out  8  latched usb_din
read_data  in  8  from register block
reg_read  out  1  one-cycle read pulse
reg_write  out  1  one-cycle write pulse
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: state IDLE; all outputs 0. Synchronizer and edge-history flops go to 1 (inactive).
- A strobe held low through reset does not start a transaction. It must rise and fall again.
- Edge detect: a falling edge is recorded on the synchronized strobe at cycle T. It is qualified only while synchronized usb_cen is 0.
- The host guarantees that usb_addr/usb_din are stable for the whole strobe. They are sampled unsynchronized at the detect edge.
- States: IDLE, RD_LAT, RD_HOLD, WR_HOLD, ABORT.
- IDLE, read fall detected at T:
  - reg_address, reg_bytecnt latched.
  - reg_read is 1 during cycle T+1 only.
  - usb_isout goes 1 from T+1.
  - Next state RD_LAT with counter = pREAD_LATENCY.
- RD_LAT: counts down. At the end of cycle T+1+pREAD_LATENCY, read_data is captured into usb_dout. Next state RD_HOLD.
- RD_HOLD: hold usb_dout and usb_isout=1. On a synchronized usb_rdn rising edge, usb_isout goes 0 the next cycle and the state returns to IDLE. usb_dout keeps its last value.
- If rdn rises during RD_LAT: the capture still completes, then the state goes directly to IDLE with usb_isout 0.
- IDLE, write fall detected at T:
  - reg_address, reg_bytecnt, write_data latched.
  - reg_write is 1 during cycle T+1 only.
  - Next state WR_HOLD.
- WR_HOLD: wait for the synchronized usb_wrn rising edge, then IDLE. write_data and address stay held.
- Read and write falls detected in the same cycle: no access, proto_err set, state ABORT. ABORT waits until both strobes are high, then IDLE.
- Any strobe falling edge outside IDLE (other than the one being serviced) is ignored and sets proto_err.
- proto_err clears only on fpga_reset.
- reg_read and reg_write are never high together. Each is at most one cycle per strobe.
- Reset mid-operation: the state machine aborts immediately. An outstanding reg_read/reg_write pulse is dropped and usb_isout goes 0 the next edge.
- Minimum strobe low time: pSYNC_STAGES+pREAD_LATENCY+3 usb_clk cycles. Shorter pulses are undefined.

Decomposition:
- Shared package/defines: state encodings (FE_IDLE, FE_RD_LAT, FE_RD_HOLD, FE_WR_HOLD, FE_ABORT) and the address-field split macros.
- One sub-module, usb_strobe_sync: a pSYNC_STAGES synchronizer plus falling/rising edge detector, parameterized by reset value. It is instantiated three times, for cen, rdn and wrn.

Test Plan:
- Write addr={REG=0x05,bytecnt=2}, din=0xA5, wrn low 10 cycles -> exactly one reg_write pulse with reg_address=0x05, reg_bytecnt=2, write_data=0xA5; proto_err=0.
- Read with read_data model returning 0x3C one cycle after reg_read -> single reg_read pulse; usb_dout=0x3C at cycle T+2+pREAD_LATENCY; usb_isout 1 until rdn rises, then 0 within pSYNC_STAGES+1 cycles.
- Strobes with usb_cen=1 -> no reg_read/reg_write, usb_isout stays 0.
- rdn and wrn fall on the same usb_clk edge -> no pulses, proto_err=1, return to IDLE after both high; proto_err persists until fpga_reset.
- fpga_reset asserted in RD_HOLD with rdn still low -> usb_isout 0 next cycle; no new reg_read until rdn toggles high then low.
- Four back-to-back writes to bytecnt 0..3 of REG_ECHO, then read-back -> returned bytes match 0x11,0x22,0x33,0x44.

Source files
------------

// File: rtl/usb_reg_fe_sync_pkg.sv
// Shared definitions for the CW305 host-bus front end: FSM encodings, access decode
// and host address-field split helpers.
`ifndef USB_REG_FE_SYNC_PKG_SV
`define USB_REG_FE_SYNC_PKG_SV

`define FE_ADDR_REG(addr, bc_w)     addr[(bc_w)+7:(bc_w)]
`define FE_ADDR_BYTECNT(addr, bc_w) addr[(bc_w)-1:0]

package usb_reg_fe_sync_pkg;

    localparam logic [2:0] FE_IDLE    = 3'd0;
    localparam logic [2:0] FE_RD_LAT  = 3'd1;
    localparam logic [2:0] FE_RD_HOLD = 3'd2;
    localparam logic [2:0] FE_WR_HOLD = 3'd3;
    localparam logic [2:0] FE_ABORT   = 3'd4;

    typedef enum logic [1:0] {
        FE_ACC_NONE,
        FE_ACC_READ,
        FE_ACC_WRITE,
        FE_ACC_CLASH
    } fe_acc_e;

    // Qualified strobe falls seen in the same cycle are ambiguous and become a clash.
    function automatic fe_acc_e fe_decode(input logic rd_go, input logic wr_go);
        fe_acc_e acc;
        acc = FE_ACC_NONE;
        if (rd_go && wr_go) begin
            acc = FE_ACC_CLASH;
        end else if (rd_go) begin
            acc = FE_ACC_READ;
        end else if (wr_go) begin
            acc = FE_ACC_WRITE;
        end
        return acc;
    endfunction

endpackage

`endif

// File: rtl/usb_reg_fe_sync_if.sv
// Host parallel-bus and register-block interfaces used by the usb_reg_fe_sync front end.
interface usb_host_if #(
    parameter int pADDR_WIDTH = 21
);
    logic [pADDR_WIDTH-1:0] usb_addr;
    logic [7:0]             usb_din;
    logic [7:0]             usb_dout;
    logic                   usb_isout;
    logic                   usb_cen;
    logic                   usb_rdn;
    logic                   usb_wrn;

    modport master (
        output usb_addr, usb_din, usb_cen, usb_rdn, usb_wrn,
        input  usb_dout, usb_isout
    );

    modport slave (
        input  usb_addr, usb_din, usb_cen, usb_rdn, usb_wrn,
        output usb_dout, usb_isout
    );
endinterface

interface usb_reg_if #(
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic [7:0]               read_data;
    logic                     reg_read;
    logic                     reg_write;

    modport master (
        output reg_address, reg_bytecnt, write_data, reg_read, reg_write,
        input  read_data
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data, reg_read, reg_write,
        output read_data
    );
endinterface

// File: rtl/usb_reg_fe_sync_strobe_sync.sv
// Multi-stage synchronizer with falling/rising edge detect for one asynchronous host strobe.
// Edges are reported only after the strobe has been observed at its idle level since reset.
module usb_strobe_sync
    import usb_reg_fe_sync_pkg::*;
#(
    parameter int   pSYNC_STAGES = 2,
    parameter logic pRESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic fall,
    output logic rise
);

    logic [pSYNC_STAGES-1:0] chain_q, chain_d;
    logic [pSYNC_STAGES-1:0] fill_q, fill_d;
    logic                    prev_q, prev_d;
    logic                    armed_q, armed_d;

    // fill_q tracks which chain stages hold real samples rather than reset values,
    // so a strobe held active through reset cannot masquerade as a fresh edge.
    always_comb begin
        chain_d = {chain_q[pSYNC_STAGES-2:0], din};
        fill_d  = {fill_q[pSYNC_STAGES-2:0], 1'b1};
        prev_d  = chain_q[pSYNC_STAGES-1];
        armed_d = armed_q | (fill_q[pSYNC_STAGES-1] & (chain_q[pSYNC_STAGES-1] == pRESET_VAL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {pSYNC_STAGES{pRESET_VAL}};
            fill_q  <= '0;
            prev_q  <= pRESET_VAL;
            armed_q <= 1'b0;
        end else begin
            chain_q <= chain_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign sync = chain_q[pSYNC_STAGES-1];
    assign fall = armed_q & prev_q & ~sync;
    assign rise = armed_q & ~prev_q & sync;

endmodule

// File: rtl/usb_reg_fe_sync.sv
// CW305 host parallel bus to usb_clk register interface: one register access per
// qualified host strobe, read data returned on usb_dout while usb_rdn is held low.
module usb_reg_fe_sync
    import usb_reg_fe_sync_pkg::*;
#(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pADDR_WIDTH   = 21,
    parameter int pREAD_LATENCY = 1,
    parameter int pSYNC_STAGES  = 2
) (
    input  logic      usb_clk,
    input  logic      fpga_reset,
    usb_host_if.slave host,
    usb_reg_if.master regs,
    output logic      proto_err
);

    localparam int CNT_W = (pREAD_LATENCY > 0) ? $clog2(pREAD_LATENCY + 1) : 1;

    logic cen_s, rdn_s, wrn_s;
    logic cen_fall, cen_rise, rd_fall, rd_rise, wr_fall, wr_rise;
    logic rd_go, wr_go;
    logic sync_unused;

    logic [2:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     rd_rise_seen_q, rd_rise_seen_d;
    logic [7:0]               reg_address_q, reg_address_d;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q, reg_bytecnt_d;
    logic [7:0]               write_data_q, write_data_d;
    logic [7:0]               usb_dout_q, usb_dout_d;
    logic                     usb_isout_q, usb_isout_d;
    logic                     reg_read_q, reg_read_d;
    logic                     reg_write_q, reg_write_d;
    logic                     proto_err_q, proto_err_d;

    usb_strobe_sync #(.pSYNC_STAGES(pSYNC_STAGES), .pRESET_VAL(1'b1)) u_cen_sync (
        .clk(usb_clk), .rst(fpga_reset), .din(host.usb_cen),
        .sync(cen_s), .fall(cen_fall), .rise(cen_rise)
    );

    usb_strobe_sync #(.pSYNC_STAGES(pSYNC_STAGES), .pRESET_VAL(1'b1)) u_rdn_sync (
        .clk(usb_clk), .rst(fpga_reset), .din(host.usb_rdn),
        .sync(rdn_s), .fall(rd_fall), .rise(rd_rise)
    );

    usb_strobe_sync #(.pSYNC_STAGES(pSYNC_STAGES), .pRESET_VAL(1'b1)) u_wrn_sync (
        .clk(usb_clk), .rst(fpga_reset), .din(host.usb_wrn),
        .sync(wrn_s), .fall(wr_fall), .rise(wr_rise)
    );

    // Chip-enable is used as a level only; address bits above the register field are don't-care.
    assign sync_unused = ^{cen_fall, cen_rise, host.usb_addr};

    assign rd_go = rd_fall & ~cen_s;
    assign wr_go = wr_fall & ~cen_s;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_rise_seen_d = rd_rise_seen_q;
        reg_address_d  = reg_address_q;
        reg_bytecnt_d  = reg_bytecnt_q;
        write_data_d   = write_data_q;
        usb_dout_d     = usb_dout_q;
        usb_isout_d    = usb_isout_q;
        reg_read_d     = 1'b0;
        reg_write_d    = 1'b0;
        proto_err_d    = proto_err_q;

        case (state_q)
            FE_IDLE: begin
                case (fe_decode(rd_go, wr_go))
                    FE_ACC_CLASH: begin
                        proto_err_d = 1'b1;
                        state_d     = FE_ABORT;
                    end
                    FE_ACC_READ: begin
                        reg_address_d  = `FE_ADDR_REG(host.usb_addr, pBYTECNT_SIZE);
                        reg_bytecnt_d  = `FE_ADDR_BYTECNT(host.usb_addr, pBYTECNT_SIZE);
                        reg_read_d     = 1'b1;
                        usb_isout_d    = 1'b1;
                        cnt_d          = CNT_W'(pREAD_LATENCY);
                        rd_rise_seen_d = 1'b0;
                        state_d        = FE_RD_LAT;
                    end
                    FE_ACC_WRITE: begin
                        reg_address_d = `FE_ADDR_REG(host.usb_addr, pBYTECNT_SIZE);
                        reg_bytecnt_d = `FE_ADDR_BYTECNT(host.usb_addr, pBYTECNT_SIZE);
                        write_data_d  = host.usb_din;
                        reg_write_d   = 1'b1;
                        state_d       = FE_WR_HOLD;
                    end
                    default: ;
                endcase
            end

            // An early rdn release is remembered so the capture still completes first.
            FE_RD_LAT: begin
                if (rd_go || wr_go) proto_err_d = 1'b1;
                if (rd_rise) rd_rise_seen_d = 1'b1;
                if (cnt_q == '0) begin
                    usb_dout_d = regs.read_data;
                    if (rd_rise_seen_q || rd_rise) begin
                        usb_isout_d = 1'b0;
                        state_d     = FE_IDLE;
                    end else begin
                        state_d = FE_RD_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            FE_RD_HOLD: begin
                if (rd_go || wr_go) proto_err_d = 1'b1;
                if (rd_rise) begin
                    usb_isout_d = 1'b0;
                    state_d     = FE_IDLE;
                end
            end

            FE_WR_HOLD: begin
                if (rd_go || wr_go) proto_err_d = 1'b1;
                if (wr_rise) state_d = FE_IDLE;
            end

            FE_ABORT: begin
                if (rd_go || wr_go) proto_err_d = 1'b1;
                if (rdn_s && wrn_s) state_d = FE_IDLE;
            end

            default: begin
                usb_isout_d = 1'b0;
                state_d     = FE_IDLE;
            end
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (fpga_reset) begin
            state_q        <= FE_IDLE;
            cnt_q          <= '0;
            rd_rise_seen_q <= 1'b0;
            reg_address_q  <= '0;
            reg_bytecnt_q  <= '0;
            write_data_q   <= '0;
            usb_dout_q     <= '0;
            usb_isout_q    <= 1'b0;
            reg_read_q     <= 1'b0;
            reg_write_q    <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_rise_seen_q <= rd_rise_seen_d;
            reg_address_q  <= reg_address_d;
            reg_bytecnt_q  <= reg_bytecnt_d;
            write_data_q   <= write_data_d;
            usb_dout_q     <= usb_dout_d;
            usb_isout_q    <= usb_isout_d;
            reg_read_q     <= reg_read_d;
            reg_write_q    <= reg_write_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign regs.reg_address = reg_address_q;
    assign regs.reg_bytecnt = reg_bytecnt_q;
    assign regs.write_data  = write_data_q;
    assign regs.reg_read    = reg_read_q;
    assign regs.reg_write   = reg_write_q;
    assign host.usb_dout    = usb_dout_q;
    assign host.usb_isout   = usb_isout_q;
    assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_usb_reg_fe_sync.sv
// Self-checking bench for usb_reg_fe_sync: table vectors, hand-written corner sequences
// and random host transactions scored against a behavioural register-file model.
module tb_usb_reg_fe_sync;

    localparam int BC_W    = 7;
    localparam int AW      = 21;
    localparam int LAT     = 1;
    localparam int SYNC    = 2;
    localparam int UPPER_W = AW - BC_W - 8;
    localparam logic [7:0] REG_ECHO = 8'h10;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;

    always #5 clk = ~clk;

    usb_host_if #(.pADDR_WIDTH(AW))  host ();
    usb_reg_if  #(.pBYTECNT_SIZE(BC_W)) regs ();

    usb_reg_fe_sync #(
        .pBYTECNT_SIZE(BC_W),
        .pADDR_WIDTH(AW),
        .pREAD_LATENCY(LAT),
        .pSYNC_STAGES(SYNC)
    ) dut (
        .usb_clk(clk),
        .fpga_reset(rst),
        .host(host),
        .regs(regs),
        .proto_err(proto_err)
    );

    // Register block: stores writes, returns read data one cycle after reg_read.
    bit [7:0] env_mem [0:32767];
    bit [7:0] rd_q;
    always_ff @(posedge clk) begin
        if (regs.reg_write) env_mem[{regs.reg_address, regs.reg_bytecnt}] <= regs.write_data;
        if (regs.reg_read)  rd_q <= env_mem[{regs.reg_address, regs.reg_bytecnt}];
    end
    assign regs.read_data = rd_q;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    logic [7:0]      mon_addr = '0;
    logic [BC_W-1:0] mon_bc   = '0;
    logic [7:0]      mon_wd   = '0;

    always @(negedge clk) begin
        if (regs.reg_read || regs.reg_write) begin
            checks++;
            if (regs.reg_read && regs.reg_write) begin
                errors++;
                $display("FAIL pulse_overlap: reg_read=%0b reg_write=%0b, required not both", regs.reg_read, regs.reg_write);
            end
            mon_addr = regs.reg_address;
            mon_bc   = regs.reg_bytecnt;
            mon_wd   = regs.write_data;
        end
        if (regs.reg_read)  rd_pulses++;
        if (regs.reg_write) wr_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the register file seen by the host is last-written-value per address.
    logic [7:0] model_mem [int];

    function automatic logic [7:0] model_rd(input logic [7:0] r, input logic [BC_W-1:0] bc);
        int k;
        k = int'({r, bc});
        return model_mem.exists(k) ? model_mem[k] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [7:0] r, input logic [BC_W-1:0] bc, input logic [7:0] d,
                            input int hold, input string name);
        int rd0, wr0;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        host.usb_addr = {UPPER_W'($urandom), r, bc};
        host.usb_din  = d;
        host.usb_cen  = 1'b0;
        tick(1);
        host.usb_wrn = 1'b0;
        tick(hold);
        host.usb_wrn = 1'b1;
        tick(SYNC + 2);
        host.usb_cen = 1'b1;
        check({name, "_wr_pulses"}, wr_pulses - wr0, 1);
        check({name, "_rd_pulses"}, rd_pulses - rd0, 0);
        check({name, "_wr_addr"}, mon_addr, r);
        check({name, "_wr_bc"}, mon_bc, bc);
        check({name, "_wr_data"}, mon_wd, d);
        model_mem[int'({r, bc})] = d;
        tick(2);
    endtask

    task automatic do_read(input logic [7:0] r, input logic [BC_W-1:0] bc, input int hold,
                           input logic [7:0] exp, input string name);
        int rd0, wr0;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        host.usb_addr = {UPPER_W'($urandom), r, bc};
        host.usb_din  = 8'($urandom);
        host.usb_cen  = 1'b0;
        tick(1);
        host.usb_rdn = 1'b0;
        tick(hold);
        check({name, "_dout"}, host.usb_dout, exp);
        check({name, "_isout_held"}, host.usb_isout, 1);
        host.usb_rdn = 1'b1;
        tick(SYNC + 1);
        check({name, "_isout_release"}, host.usb_isout, 0);
        check({name, "_dout_kept"}, host.usb_dout, exp);
        check({name, "_rd_pulses"}, rd_pulses - rd0, 1);
        check({name, "_wr_pulses"}, wr_pulses - wr0, 0);
        check({name, "_rd_addr"}, mon_addr, r);
        host.usb_cen = 1'b1;
        tick(2);
    endtask

    typedef struct {
        bit              wr;
        logic [7:0]      r;
        logic [BC_W-1:0] bc;
        logic [7:0]      d;
        logic [7:0]      exp;
    } vec_t;

    vec_t vt [10];

    initial begin
        int rd0, wr0, found;

        vt[0] = '{wr: 1'b1, r: 8'h05,   bc: 7'd2, d: 8'hA5, exp: 8'h00};
        vt[1] = '{wr: 1'b1, r: REG_ECHO, bc: 7'd0, d: 8'h11, exp: 8'h00};
        vt[2] = '{wr: 1'b1, r: REG_ECHO, bc: 7'd1, d: 8'h22, exp: 8'h00};
        vt[3] = '{wr: 1'b1, r: REG_ECHO, bc: 7'd2, d: 8'h33, exp: 8'h00};
        vt[4] = '{wr: 1'b1, r: REG_ECHO, bc: 7'd3, d: 8'h44, exp: 8'h00};
        vt[5] = '{wr: 1'b0, r: REG_ECHO, bc: 7'd0, d: 8'h00, exp: 8'h11};
        vt[6] = '{wr: 1'b0, r: REG_ECHO, bc: 7'd1, d: 8'h00, exp: 8'h22};
        vt[7] = '{wr: 1'b0, r: REG_ECHO, bc: 7'd2, d: 8'h00, exp: 8'h33};
        vt[8] = '{wr: 1'b0, r: REG_ECHO, bc: 7'd3, d: 8'h00, exp: 8'h44};
        vt[9] = '{wr: 1'b0, r: 8'h05,   bc: 7'd2, d: 8'h00, exp: 8'hA5};

        rst           = 1'b1;
        host.usb_addr = '0;
        host.usb_din  = '0;
        host.usb_cen  = 1'b1;
        host.usb_rdn  = 1'b1;
        host.usb_wrn  = 1'b1;
        tick(4);

        check("rst_dout", host.usb_dout, 0);
        check("rst_isout", host.usb_isout, 0);
        check("rst_reg_read", regs.reg_read, 0);
        check("rst_reg_write", regs.reg_write, 0);
        check("rst_reg_address", regs.reg_address, 0);
        check("rst_reg_bytecnt", regs.reg_bytecnt, 0);
        check("rst_write_data", regs.write_data, 0);
        check("rst_proto_err", proto_err, 0);

        rst = 1'b0;
        tick(SYNC + 4);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].wr) do_write(vt[i].r, vt[i].bc, vt[i].d, 10, $sformatf("tab%0d", i));
            else          do_read(vt[i].r, vt[i].bc, 10, vt[i].exp, $sformatf("tab%0d", i));
        end
        check("tab_proto_err", proto_err, 0);

        // Read latency: usb_dout must change exactly LAT+1 cycles after the reg_read cycle.
        do_write(8'h22, 7'd5, 8'h3C, 9, "lat_wr");
        rd0 = rd_pulses;
        host.usb_addr = {UPPER_W'(0), 8'h22, 7'd5};
        host.usb_cen  = 1'b0;
        tick(1);
        host.usb_rdn = 1'b0;
        found = 0;
        for (int i = 0; i < SYNC + 6; i++) begin
            tick(1);
            if (regs.reg_read) begin
                found = 1;
                break;
            end
        end
        check("lat_reg_read_seen", found, 1);
        if (found == 1) begin
            check("lat_isout_t1", host.usb_isout, 1);
            tick(LAT);
            check("lat_dout_before", host.usb_dout, 8'hA5);
            tick(1);
            check("lat_dout_at", host.usb_dout, 8'h3C);
        end
        tick(4);
        host.usb_rdn = 1'b1;
        tick(SYNC);
        check("lat_isout_still", host.usb_isout, 1);
        tick(1);
        check("lat_isout_off", host.usb_isout, 0);
        check("lat_rd_pulses", rd_pulses - rd0, 1);
        host.usb_cen = 1'b1;
        tick(3);

        // Strobes with chip enable inactive are not accesses.
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        host.usb_addr = {UPPER_W'(0), REG_ECHO, 7'd0};
        tick(1);
        host.usb_rdn = 1'b0;
        tick(6);
        check("cen_isout_rd", host.usb_isout, 0);
        tick(4);
        host.usb_rdn = 1'b1;
        tick(4);
        host.usb_wrn = 1'b0;
        tick(10);
        host.usb_wrn = 1'b1;
        tick(4);
        check("cen_rd_pulses", rd_pulses - rd0, 0);
        check("cen_wr_pulses", wr_pulses - wr0, 0);
        check("cen_isout_end", host.usb_isout, 0);
        check("cen_proto_err", proto_err, 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0]      r;
            logic [BC_W-1:0] bc;
            int              hold;
            r    = 8'h40 + 8'($urandom_range(0, 3));
            bc   = BC_W'($urandom_range(0, 3));
            hold = $urandom_range(SYNC + LAT + 4, 14);
            if ($urandom_range(0, 1) == 1) do_write(r, bc, 8'($urandom), hold, $sformatf("rnd%0d", i));
            else                           do_read(r, bc, hold, model_rd(r, bc), $sformatf("rnd%0d", i));
            tick($urandom_range(0, 3));
        end
        check("rnd_proto_err", proto_err, 0);

        // Reset while servicing a read with rdn held low.
        host.usb_addr = {UPPER_W'(0), REG_ECHO, 7'd1};
        host.usb_cen  = 1'b0;
        tick(1);
        host.usb_rdn = 1'b0;
        tick(8);
        check("rsthold_isout_before", host.usb_isout, 1);
        rst = 1'b1;
        tick(1);
        check("rsthold_isout_after", host.usb_isout, 0);
        check("rsthold_dout_after", host.usb_dout, 0);
        tick(2);
        rst = 1'b0;
        rd0 = rd_pulses;
        tick(10);
        check("rsthold_no_read", rd_pulses - rd0, 0);
        check("rsthold_isout_idle", host.usb_isout, 0);
        host.usb_rdn = 1'b1;
        tick(SYNC + 3);
        host.usb_rdn = 1'b0;
        tick(10);
        check("rsthold_new_read", rd_pulses - rd0, 1);
        check("rsthold_new_isout", host.usb_isout, 1);
        check("rsthold_new_dout", host.usb_dout, 8'h22);
        host.usb_rdn = 1'b1;
        tick(SYNC + 2);
        host.usb_cen = 1'b1;
        tick(3);

        // Read and write strobes falling together.
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        host.usb_addr = {UPPER_W'(0), REG_ECHO, 7'd2};
        host.usb_cen  = 1'b0;
        tick(1);
        host.usb_rdn = 1'b0;
        host.usb_wrn = 1'b0;
        tick(8);
        check("clash_proto_err", proto_err, 1);
        check("clash_isout", host.usb_isout, 0);
        host.usb_rdn = 1'b1;
        tick(4);
        host.usb_wrn = 1'b1;
        tick(4);
        host.usb_cen = 1'b1;
        check("clash_rd_pulses", rd_pulses - rd0, 0);
        check("clash_wr_pulses", wr_pulses - wr0, 0);
        tick(2);
        do_write(REG_ECHO, 7'd3, 8'h5A, 10, "clash_after");
        check("clash_err_sticky", proto_err, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(SYNC + 4);
        check("clash_err_cleared", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
